// File: rtl/dcmac_0_axis_pkt_gen_seg_sched.sv
// ---------------------------------------------------------------------------------------------
// dcmac_0_axis_pkt_gen_seg_sched
//
// Per-ID segment scheduler for the AXIS packet generator. Each ID owns a packet-length counter.
// IDs are picked round-robin and every issued slot carries one segment of at most MAX_SEG bytes.
// The same ID is never issued in two consecutive cycles, because the downstream buffer-context
// memories do not forward read-during-write.
//
// Optional feature macro: DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
//   When defined, lengths sampled at SOP are clamped to 64..9600 bytes, and o_len_err is present
//   as a sticky flag that records any clamp.
//
// Ports:
//   clk            single clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   i_ena          per-ID generation enable (level)
//   i_pkt_len      per-ID packet length, ID k at [k*LEN_W +: LEN_W]
//   i_ready        downstream accepts a slot this cycle
//   o_vld          slot valid
//   o_id           slot ID (holds its value when o_vld=0)
//   o_size         segment bytes, 1..MAX_SEG (holds its value when o_vld=0)
//   o_sop / o_eop  first / last segment of a packet
//   o_id_valid_p1  o_vld delayed by one clock
//   o_pkt_cnt      packets completed (EOP issued), wraps
//   o_len_err      sticky clamp flag (macro builds only)
// ---------------------------------------------------------------------------------------------

module dcmac_0_axis_pkt_gen_seg_sched #(
    parameter int unsigned  NUM_ID  = 6,
    parameter int unsigned  MAX_SEG = 64,
    parameter int unsigned  LEN_W   = 14,
    localparam int unsigned ID_W    = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_ID-1:0]       i_ena,
    input  logic [NUM_ID*LEN_W-1:0] i_pkt_len,
    input  logic                    i_ready,
    output logic                    o_vld,
    output logic [ID_W-1:0]         o_id,
    output logic [7:0]              o_size,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic                    o_id_valid_p1,
    output logic [31:0]             o_pkt_cnt
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
    ,
    output logic                    o_len_err
`endif
);

    localparam logic [ID_W:0]  NumIdW   = (ID_W + 1)'(NUM_ID);
    localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_ID - 1);
    localparam logic [LEN_W-1:0] MaxSegL = LEN_W'(MAX_SEG);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [NUM_ID-1:0] active_q, active_d;     // 1 = packet in progress (ACTIVE)
    logic [LEN_W-1:0]  rem_q [NUM_ID];          // bytes still to send for the ACTIVE packet
    logic [LEN_W-1:0]  rem_d [NUM_ID];
    logic [ID_W-1:0]   last_grant_q;

    logic              vld_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        size_q;
    logic              sop_q;
    logic              eop_q;
    logic              vld_p1_q;
    logic [31:0]       pkt_cnt_q;

    // -----------------------------------------------------------------------------------------
    // Per-ID length extraction (and optional clamp)
    // -----------------------------------------------------------------------------------------
    logic [LEN_W-1:0]  len_raw [NUM_ID];
    logic [LEN_W-1:0]  len_eff [NUM_ID];
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
    logic [NUM_ID-1:0] len_clamp;
    logic              len_err_q;
`endif

    always_comb begin
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
        len_clamp = '0;
`endif
        for (int k = 0; k < NUM_ID; k++) begin
            len_raw[k] = i_pkt_len[k*LEN_W +: LEN_W];
            len_eff[k] = len_raw[k];
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
            // Zero is left alone: it means "never eligible", not a short packet.
            if ((len_raw[k] != '0) && (32'(len_raw[k]) < 32'd64)) begin
                len_eff[k]   = LEN_W'(64);
                len_clamp[k] = 1'b1;
            end else if (32'(len_raw[k]) > 32'd9600) begin
                len_eff[k]   = LEN_W'(9600);
                len_clamp[k] = 1'b1;
            end
`endif
        end
    end

    // -----------------------------------------------------------------------------------------
    // Eligibility: ACTIVE ignores the enable; IDLE needs enable and a non-zero length.
    // The ID shown on the registered outputs last cycle is excluded (no read-during-write).
    // -----------------------------------------------------------------------------------------
    logic [NUM_ID-1:0] elig;

    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_ID; k++) begin
            elig[k] = (active_q[k] | (i_ena[k] & (len_raw[k] != '0)))
                      & ~(vld_q & (id_q == ID_W'(k)));
        end
    end

    // -----------------------------------------------------------------------------------------
    // Round-robin arbiter: search from last_grant+1, wrapping modulo NUM_ID.
    // -----------------------------------------------------------------------------------------
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_ID; off++) begin
            cand_sum = {1'b0, last_grant_q} + (ID_W + 1)'(off);
            if (cand_sum >= NumIdW) begin
                cand_sum = cand_sum - NumIdW;
            end
            cand = cand_sum[ID_W-1:0];
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    logic issue;
    assign issue = i_ready & grant_vld;

    // -----------------------------------------------------------------------------------------
    // Segment computation for the granted ID
    // -----------------------------------------------------------------------------------------
    logic             sel_active;
    logic [LEN_W-1:0] seg_val;
    logic [LEN_W-1:0] seg_rem;
    logic [7:0]       seg_size;
    logic             seg_eop;

    always_comb begin
        sel_active = active_q[grant_id];
        // IDLE IDs start a new packet from the length sampled right now.
        seg_val    = sel_active ? rem_q[grant_id] : len_eff[grant_id];
        if (32'(seg_val) > MAX_SEG) begin
            seg_size = 8'(MAX_SEG);
            seg_rem  = seg_val - MaxSegL;
            seg_eop  = 1'b0;
        end else begin
            seg_size = 8'(seg_val);
            seg_rem  = '0;
            seg_eop  = 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Per-ID next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        active_d = active_q;
        rem_d    = rem_q;
        if (issue) begin
            active_d[grant_id] = ~seg_eop;
            rem_d[grant_id]    = seg_rem;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= '0;
            for (int k = 0; k < NUM_ID; k++) begin
                rem_q[k] <= '0;
            end
            last_grant_q <= LastId;     // so that ID 0 wins the first arbitration
            vld_q        <= 1'b0;
            id_q         <= '0;
            size_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            vld_p1_q     <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
            vld_p1_q <= vld_q;
            if (issue) begin
                vld_q        <= 1'b1;
                id_q         <= grant_id;
                size_q       <= seg_size;
                sop_q        <= ~sel_active;
                eop_q        <= seg_eop;
                last_grant_q <= grant_id;
                if (seg_eop) begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                end
            end else begin
                // id/size hold their last issued value on a bubble
                vld_q <= 1'b0;
                sop_q <= 1'b0;
                eop_q <= 1'b0;
            end
        end
    end

`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err_q <= 1'b0;
        end else if (issue && !sel_active && len_clamp[grant_id]) begin
            len_err_q <= 1'b1;
        end
    end

    assign o_len_err = len_err_q;
`endif

    assign o_vld         = vld_q;
    assign o_id          = id_q;
    assign o_size        = size_q;
    assign o_sop         = sop_q;
    assign o_eop         = eop_q;
    assign o_id_valid_p1 = vld_p1_q;
    assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_seg_sched.sv
// ---------------------------------------------------------------------------------------------
// Testbench for dcmac_0_axis_pkt_gen_seg_sched.
// Driver applies inputs on the falling edge and pushes the expected registered outputs for the
// following rising edge into a scoreboard queue; a monitor pops and compares 1 ns after each
// rising edge. The reference model tracks bytes remaining per ID as plain integers.
// ---------------------------------------------------------------------------------------------

module tb_dcmac_0_axis_pkt_gen_seg_sched;

    localparam int NUM_ID  = 6;
    localparam int MAX_SEG = 64;
    localparam int LEN_W   = 14;
    localparam int ID_W    = 3;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_ID-1:0]       i_ena;
    logic [NUM_ID*LEN_W-1:0] i_pkt_len;
    logic                    i_ready;
    logic                    o_vld;
    logic [ID_W-1:0]         o_id;
    logic [7:0]              o_size;
    logic                    o_sop;
    logic                    o_eop;
    logic                    o_id_valid_p1;
    logic [31:0]             o_pkt_cnt;
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
    logic                    o_len_err;
`endif

    dcmac_0_axis_pkt_gen_seg_sched #(
        .NUM_ID  (NUM_ID),
        .MAX_SEG (MAX_SEG),
        .LEN_W   (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (i_ena),
        .i_pkt_len     (i_pkt_len),
        .i_ready       (i_ready),
        .o_vld         (o_vld),
        .o_id          (o_id),
        .o_size        (o_size),
        .o_sop         (o_sop),
        .o_eop         (o_eop),
        .o_id_valid_p1 (o_id_valid_p1),
        .o_pkt_cnt     (o_pkt_cnt)
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
        ,
        .o_len_err     (o_len_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int id;
        int size;
        bit sop;
        bit eop;
        bit p1;
        int cnt;
        bit err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   slot_no  = 0;

    // Stimulus variables applied to the pins on each driven cycle
    bit [NUM_ID-1:0] tb_ena;
    int              tb_len [NUM_ID];
    bit              tb_rdy;

    // Reference model state
    int m_rem [NUM_ID];    // >0 means a packet is in progress
    int m_last;
    int m_prev_id;         // -1 when the previous cycle was a bubble
    bit m_prev_vld;
    int m_cnt;
    int m_id_hold;
    int m_size_hold;
    bit m_err;

    function automatic void model_reset();
        for (int k = 0; k < NUM_ID; k++) m_rem[k] = 0;
        m_last      = NUM_ID - 1;
        m_prev_id   = -1;
        m_prev_vld  = 1'b0;
        m_cnt       = 0;
        m_id_hold   = 0;
        m_size_hold = 0;
        m_err       = 1'b0;
    endfunction

    function automatic int clamp_len(input int len);
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
        if (len != 0 && len < 64) begin
            m_err = 1'b1;
            return 64;
        end
        if (len > 9600) begin
            m_err = 1'b1;
            return 9600;
        end
`endif
        return len;
    endfunction

    // One cycle of the scheduler rules; pushes the expected outputs after the next rising edge.
    function automatic void model_step();
        exp_t e;
        int   win;
        int   k;
        int   v;
        win = -1;
        if (tb_rdy) begin
            for (int off = 1; off <= NUM_ID; off++) begin
                k = (m_last + off) % NUM_ID;
                if (win < 0 && k != m_prev_id &&
                    (m_rem[k] > 0 || (tb_ena[k] && tb_len[k] != 0))) begin
                    win = k;
                end
            end
        end
        e.p1 = m_prev_vld;
        e.sop = 1'b0;
        e.eop = 1'b0;
        if (win >= 0) begin
            e.vld = 1'b1;
            e.sop = (m_rem[win] == 0);
            v = e.sop ? clamp_len(tb_len[win]) : m_rem[win];
            if (v > MAX_SEG) begin
                m_size_hold = MAX_SEG;
                m_rem[win]  = v - MAX_SEG;
            end else begin
                m_size_hold = v;
                m_rem[win]  = 0;
                e.eop       = 1'b1;
                m_cnt++;
            end
            m_id_hold = win;
            m_last    = win;
            m_prev_id = win;
        end else begin
            e.vld     = 1'b0;
            m_prev_id = -1;
        end
        m_prev_vld = e.vld;
        e.id   = m_id_hold;
        e.size = m_size_hold;
        e.cnt  = m_cnt;
        e.err  = m_err;
        q.push_back(e);
    endfunction

    task automatic apply_inputs();
        i_ena   = tb_ena;
        i_ready = tb_rdy;
        for (int k = 0; k < NUM_ID; k++) i_pkt_len[k*LEN_W +: LEN_W] = LEN_W'(tb_len[k]);
    endtask

    task automatic drive_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            apply_inputs();
            model_step();
        end
    endtask

    task automatic set_all_len(input int len);
        for (int k = 0; k < NUM_ID; k++) tb_len[k] = len;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " o_vld"}, int'(o_vld), 0);
        chk({tag, " o_id"}, int'(o_id), 0);
        chk({tag, " o_size"}, int'(o_size), 0);
        chk({tag, " o_sop"}, int'(o_sop), 0);
        chk({tag, " o_eop"}, int'(o_eop), 0);
        chk({tag, " o_id_valid_p1"}, int'(o_id_valid_p1), 0);
        chk({tag, " o_pkt_cnt"}, int'(o_pkt_cnt), 0);
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
        chk({tag, " o_len_err"}, int'(o_len_err), 0);
`endif
    endtask

    // Monitor: compares one expected record per driven cycle
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q.size() > 0) begin
                e  = q.pop_front();
                ok = (o_vld == e.vld) && (int'(o_id) == e.id) && (int'(o_size) == e.size) &&
                     (o_sop == e.sop) && (o_eop == e.eop) && (o_id_valid_p1 == e.p1) &&
                     (int'(o_pkt_cnt) == e.cnt);
`ifdef DCMAC_0_PKT_GEN_SCHED_LEN_CHK_EN
                ok = ok && (o_len_err == e.err);
`endif
                n_checks++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL slot %0d: got vld=%0b id=%0d size=%0d sop=%0b eop=%0b p1=%0b cnt=%0d, expected vld=%0b id=%0d size=%0d sop=%0b eop=%0b p1=%0b cnt=%0d err=%0b",
                             slot_no, o_vld, o_id, o_size, o_sop, o_eop, o_id_valid_p1,
                             o_pkt_cnt, e.vld, e.id, e.size, e.sop, e.eop, e.p1, e.cnt,
                             e.err);
                end
                slot_no++;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        tb_ena = '0;
        tb_rdy = 1'b0;
        set_all_len(0);
        apply_inputs();
        model_reset();

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        model_step();
        mon_en = 1'b1;

        // All IDs, 64-byte packets: 0..5 round-robin every cycle, single-segment packets
        tb_ena = '1;
        tb_rdy = 1'b1;
        set_all_len(64);
        drive_cycles(14);

        // Only ID 2, 150 bytes: 64, bubble, 64, bubble, 22
        tb_ena = 6'b000100;
        set_all_len(150);
        drive_cycles(12);

        // IDs 0 and 1, 128 bytes, ready toggling
        tb_ena = 6'b000011;
        set_all_len(128);
        for (int c = 0; c < 12; c++) begin
            tb_rdy = (c % 3) != 1;
            drive_cycles(1);
        end
        tb_rdy = 1'b1;
        tb_ena = '0;
        drive_cycles(6);

        // ID 3, 200 bytes, enable dropped after the first segment
        tb_ena = 6'b001000;
        set_all_len(200);
        drive_cycles(1);
        tb_ena = '0;
        drive_cycles(10);

        // Short length: clamped to 64 with the length check, passed through otherwise
        tb_ena = 6'b000010;
        set_all_len(20);
        drive_cycles(1);
        tb_ena = '0;
        drive_cycles(4);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) tb_ena = NUM_ID'($urandom);
            for (int k = 0; k < NUM_ID; k++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 9))
                        0:       tb_len[k] = 0;
                        1:       tb_len[k] = $urandom_range(1, 63);
                        2:       tb_len[k] = 64 * $urandom_range(1, 3);
                        3:       tb_len[k] = 9700;
                        default: tb_len[k] = $urandom_range(1, 400);
                    endcase
                end
            end
            tb_rdy = ($urandom_range(0, 3) != 0);
            drive_cycles(1);
        end

        // Reset mid-packet: asynchronous clear, then ID 0 restarts with a full packet
        tb_ena = '1;
        tb_rdy = 1'b1;
        set_all_len(300);
        drive_cycles(8);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async reset");
        tb_rdy = 1'b0;
        apply_inputs();
        model_reset();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
        mon_en = 1'b1;
        tb_rdy = 1'b1;
        drive_cycles(20);

        tb_ena = '0;
        drive_cycles(2);
        @(posedge clk);
        #2;
        chk("scoreboard drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
